// File: rtl/mdu_hilo_if.sv
// Handshake and result bus between the pipeline controller and the HI/LO multiply/divide unit.
interface mdu_hilo_if;
   logic        start;
   logic [1:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        mthi;
   logic        mtlo;
   logic [31:0] wdata;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;

   modport master (
      output start, op, a, b, mthi, mtlo, wdata,
      input  busy, done, hi, lo
   );

   modport slave (
      input  start, op, a, b, mthi, mtlo, wdata,
      output busy, done, hi, lo
   );
endinterface

// File: rtl/mdu_hilo.sv
// Iterative MULT/MULTU/DIV/DIVU unit with the architectural HI/LO pair.
// Define MDU_FAST_MUL_EN to commit multiplies one cycle after acceptance.
module mdu_hilo (
   input  logic       clk,
   input  logic       rst,
   mdu_hilo_if.slave  bus
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] FIX  = 2'd2;

   logic [1:0]  state;
   logic [5:0]  cnt;
   logic [63:0] acc;       // product accumulator; low half doubles as multiplier / quotient shifter
   logic [31:0] rem;
   logic [31:0] opb;       // |b|: addend for multiply, divisor for divide
   logic [31:0] a_raw;
   logic [1:0]  op_q;
   logic        neg_q;
   logic        neg_r;
   logic        dz;
   logic [31:0] hi_q;
   logic [31:0] lo_q;
   logic        done_q;

   logic        sgn_op;
   logic [31:0] abs_a;
   logic [31:0] abs_b;
   logic [32:0] msum;
   logic [32:0] prem;
   logic [33:0] dtrial;
   logic [63:0] mul_raw;
   logic [63:0] mul_res;
   logic [31:0] fix_hi;
   logic [31:0] fix_lo;

   always_comb begin
      sgn_op = ~bus.op[0];
      abs_a  = (sgn_op && bus.a[31]) ? (32'd0 - bus.a) : bus.a;
      abs_b  = (sgn_op && bus.b[31]) ? (32'd0 - bus.b) : bus.b;
   end

   // Shift-add: low half of acc holds the remaining multiplier bits, LSB first.
   assign msum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opb} : 33'd0);
   // Restoring step: bring in the next dividend bit, subtract if it fits.
   assign prem   = {rem, acc[31]};
   assign dtrial = {1'b0, prem} - {2'b00, opb};

`ifdef MDU_FAST_MUL_EN
   assign mul_raw = {32'd0, opb} * {32'd0, acc[31:0]};
`else
   assign mul_raw = acc;
`endif

   always_comb begin
      fix_hi  = 32'd0;
      fix_lo  = 32'd0;
      mul_res = neg_q ? (64'd0 - mul_raw) : mul_raw;
      if (!op_q[1]) begin
         fix_hi = mul_res[63:32];
         fix_lo = mul_res[31:0];
      end else if (dz) begin
         fix_hi = a_raw;
         fix_lo = 32'hFFFF_FFFF;
      end else begin
         fix_lo = neg_q ? (32'd0 - acc[31:0]) : acc[31:0];
         fix_hi = neg_r ? (32'd0 - rem) : rem;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         cnt    <= 6'd0;
         acc    <= 64'd0;
         rem    <= 32'd0;
         opb    <= 32'd0;
         a_raw  <= 32'd0;
         op_q   <= 2'd0;
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
         dz     <= 1'b0;
         hi_q   <= 32'd0;
         lo_q   <= 32'd0;
         done_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.mthi) hi_q <= bus.wdata;
               if (bus.mtlo) lo_q <= bus.wdata;
               if (bus.start) begin
                  acc   <= {32'd0, abs_a};
                  rem   <= 32'd0;
                  opb   <= abs_b;
                  a_raw <= bus.a;
                  op_q  <= bus.op;
                  neg_q <= sgn_op & (bus.a[31] ^ bus.b[31]);
                  neg_r <= sgn_op & bus.a[31];
                  dz    <= (bus.b == 32'd0);
                  cnt   <= 6'd0;
`ifdef MDU_FAST_MUL_EN
                  state <= bus.op[1] ? RUN : FIX;
`else
                  state <= RUN;
`endif
               end
            end
            RUN: begin
               if (op_q[1]) begin
                  acc[31:0] <= {acc[30:0], ~dtrial[33]};
                  rem       <= dtrial[33] ? prem[31:0] : dtrial[31:0];
               end else begin
                  acc <= {msum, acc[31:1]};
               end
               cnt <= cnt + 6'd1;
               if (cnt == 6'd31) state <= FIX;
            end
            FIX: begin
               hi_q   <= fix_hi;
               lo_q   <= fix_lo;
               done_q <= 1'b1;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.busy = (state != IDLE);
   assign bus.done = done_q;
   assign bus.hi   = hi_q;
   assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mdu_hilo.sv
// Scoreboard bench for mdu_hilo: directed ops push expected HI/LO/latency, a monitor checks on done.
module tb_mdu_hilo;

   logic clk;
   logic rst;
   mdu_hilo_if bus ();

   mdu_hilo dut (.clk(clk), .rst(rst), .bus(bus));

   initial clk = 1'b0;
   always #5 clk = ~clk;

`ifdef MDU_FAST_MUL_EN
   localparam int MUL_LAT = 1;
`else
   localparam int MUL_LAT = 33;
`endif
   localparam int DIV_LAT = 33;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      int          lat;
   } exp_t;

   exp_t sb[$];
   int   vectors = 0;
   int   miscompares = 0;
   int   bcnt = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Monitor: count busy cycles, compare on every done pulse.
   always @(negedge clk) begin
      if (rst) begin
         bcnt = 0;
      end else begin
         if (bus.busy) bcnt++;
         if (bus.done) begin
            if (sb.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL unexpected_done: got done=1, expected no result pending");
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk("hi", bus.hi, e.hi);
               chk("lo", bus.lo, e.lo);
               chk("busy_cycles", 32'(bcnt), 32'(e.lat));
            end
            bcnt = 0;
         end
      end
   end

   task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el);
      exp_t e;
      @(negedge clk);
      bus.start = 1'b1;
      bus.op    = op;
      bus.a     = a;
      bus.b     = b;
      e.hi  = eh;
      e.lo  = el;
      e.lat = op[1] ? DIV_LAT : MUL_LAT;
      sb.push_back(e);
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   task automatic wait_done();
      int n = 0;
      while (sb.size() != 0 && n < 60) begin
         @(negedge clk);
         n++;
      end
      if (sb.size() != 0) begin
         vectors++;
         miscompares++;
         $display("FAIL timeout: got no done after %0d cycles, expected done", n);
         sb.delete();
      end
      @(negedge clk);
   endtask

   task automatic run(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] eh, input logic [31:0] el);
      issue(op, a, b, eh, el);
      wait_done();
   endtask

   initial begin
      rst = 1'b1;
      bus.start = 1'b0; bus.op = 2'd0; bus.a = 32'd0; bus.b = 32'd0;
      bus.mthi = 1'b0; bus.mtlo = 1'b0; bus.wdata = 32'd0;
      repeat (2) @(negedge clk);
      chk("rst_hi", bus.hi, 32'd0);
      chk("rst_lo", bus.lo, 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_done", 32'(bus.done), 32'd0);
      rst = 1'b0;

      // MTHI / MTLO in IDLE
      @(negedge clk); bus.mthi = 1'b1; bus.wdata = 32'h0000_1234;
      @(negedge clk); bus.mthi = 1'b0;
      chk("mthi", bus.hi, 32'h0000_1234);
      bus.mtlo = 1'b1; bus.wdata = 32'h0000_0055;
      @(negedge clk); bus.mtlo = 1'b0;
      chk("mtlo", bus.lo, 32'h0000_0055);
      chk("mtlo_hi_kept", bus.hi, 32'h0000_1234);
      bus.mthi = 1'b1; bus.mtlo = 1'b1; bus.wdata = 32'hAABB_CCDD;
      @(negedge clk); bus.mthi = 1'b0; bus.mtlo = 1'b0;
      chk("mthilo_hi", bus.hi, 32'hAABB_CCDD);
      chk("mthilo_lo", bus.lo, 32'hAABB_CCDD);

      // Arithmetic vectors (op: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU)
      run(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
      run(2'd0, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB);
      run(2'd2, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD);
      run(2'd3, 32'd100,       32'd0,         32'd100,       32'hFFFF_FFFF);
      run(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000);
      run(2'd2, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD);
      run(2'd2, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF);
      run(2'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0);
      run(2'd3, 32'd100,       32'd7,         32'd2,         32'd14);

      // MTLO on the accept edge lands, then FIX overwrites it
      bus.mtlo = 1'b1; bus.wdata = 32'h0000_DEAD;
      issue(2'd1, 32'd3, 32'd5, 32'd0, 32'd15);
      bus.mtlo = 1'b0;
`ifndef MDU_FAST_MUL_EN
      chk("start_mtlo_lo", bus.lo, 32'h0000_DEAD);
`endif
      wait_done();

      // MTLO and start while busy are dropped
      issue(2'd3, 32'd1000, 32'd3, 32'd1, 32'd333);
      repeat (3) @(negedge clk);
      bus.mtlo = 1'b1; bus.wdata = 32'h0000_BEEF;
      bus.start = 1'b1; bus.op = 2'd1; bus.a = 32'd2; bus.b = 32'd2;
      @(negedge clk);
      bus.mtlo = 1'b0; bus.start = 1'b0;
      chk("busy_mtlo_dropped", bus.lo, 32'd15);
      chk("busy_mid_run", 32'(bus.busy), 32'd1);
      wait_done();

      // Reset in the middle of a DIVU discards it
      issue(2'd3, 32'd50, 32'd5, 32'd0, 32'd10);
      repeat (9) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("midrst_hi", bus.hi, 32'd0);
      chk("midrst_lo", bus.lo, 32'd0);
      chk("midrst_busy", 32'(bus.busy), 32'd0);
      sb.delete();
      @(negedge clk);
      rst = 1'b0;
      repeat (40) @(negedge clk);
      chk("midrst_idle_hi", bus.hi, 32'd0);

      run(2'd1, 32'd3, 32'd5, 32'd0, 32'd15);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
